debounce_multi: RTL



---
 rtl/debounce_chan.sv | 115 +++++++++++
 rtl/debounce_multi.sv | 43 ++++
 2 files changed

// File: rtl/debounce_chan.sv
// Single debounce channel: input synchroniser, consecutive-sample filter,
// optional long-press hold counter and one-clk rise/fall/long pulses.
module debounce_chan #(
    parameter logic ACTIVE       = 1'b1,
    parameter int   NSAMP        = 3,
    parameter int   SYNC_STAGES  = 2,
    parameter int   FAST_RELEASE = 0,
    parameter int   LONG_TICKS   = 0
) (
    input  logic arst_n,
    input  logic clk,
    input  logic tick,
    input  logic inp,
    output logic out,
    output logic rise,
    output logic fall,
    output logic long
);

    localparam int            CW       = $clog2(NSAMP);
    localparam logic [CW-1:0] CNT_LAST = CW'(NSAMP - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sample;
    logic [CW-1:0]          cnt_reg;
    logic [CW-1:0]          cnt_next;
    logic                   out_reg;
    logic                   out_next;
    logic                   rise_reg;
    logic                   fall_reg;

    // Synchroniser runs every clk; it resets to the inactive pin level so a
    // released reset never looks like a press.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_reg <= {SYNC_STAGES{~ACTIVE}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], inp};
        end
    end

    // Normalise polarity: 1 means the channel is in its active state.
    assign sample = ~(sync_reg[SYNC_STAGES-1] ^ ACTIVE);

    // Filter decision for the current clk; only a tick advances anything.
    always_comb begin
        out_next = out_reg;
        cnt_next = cnt_reg;
        if (tick) begin
            if ((FAST_RELEASE != 0) && out_reg && !sample) begin
                out_next = 1'b0;
                cnt_next = '0;
            end else if (sample == out_reg) begin
                cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
                out_next = sample;
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    // Filter state plus edge pulses registered on the same edge out changes.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_reg  <= '0;
            out_reg  <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            out_reg  <= out_next;
            rise_reg <= out_next & ~out_reg;
            fall_reg <= ~out_next & out_reg;
        end
    end

    assign out  = out_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;

    generate
        if (LONG_TICKS > 0) begin : g_hold
            localparam int            HW       = $clog2(LONG_TICKS + 1);
            localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
            localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_TICKS - 1);

            logic [HW-1:0] hold_reg;
            logic          long_reg;

            // Count ticks spent active; saturate so long fires once per press.
            // A tick that also releases the channel does not count.
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    hold_reg <= '0;
                    long_reg <= 1'b0;
                end else begin
                    long_reg <= 1'b0;
                    if (!out_reg) begin
                        hold_reg <= '0;
                    end else if (tick && out_next && (hold_reg != HOLD_MAX)) begin
                        hold_reg <= hold_reg + HW'(1);
                        long_reg <= (hold_reg == HOLD_PRE);
                    end
                end
            end

            assign long = long_reg;
        end else begin : g_no_hold
            assign long = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: NCH independent debounce_chan instances sharing
// the clock, reset and periodic sample strobe.
module debounce_multi #(
    parameter int             NCH          = 4,
    parameter logic [NCH-1:0] ACTIVE       = {NCH{1'b1}},
    parameter int             NSAMP        = 3,
    parameter int             SYNC_STAGES  = 2,
    parameter int             FAST_RELEASE = 0,
    parameter int             LONG_TICKS   = 0
) (
    input  logic           arst_n,
    input  logic           clk,
    input  logic           tick,
    input  logic [NCH-1:0] inp,
    output logic [NCH-1:0] out,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] long
);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            debounce_chan #(
                .ACTIVE       (ACTIVE[gi]),
                .NSAMP        (NSAMP),
                .SYNC_STAGES  (SYNC_STAGES),
                .FAST_RELEASE (FAST_RELEASE),
                .LONG_TICKS   (LONG_TICKS)
            ) u_chan (
                .arst_n (arst_n),
                .clk    (clk),
                .tick   (tick),
                .inp    (inp[gi]),
                .out    (out[gi]),
                .rise   (rise[gi]),
                .fall   (fall[gi]),
                .long   (long[gi])
            );
        end
    endgenerate

endmodule
